// File: rtl/tx_controller.sv
// VFAT3 command transmitter: AXI4-Lite register slave feeding a byte FIFO,
// serialized MSB-first with idle bytes filling empty slots.
module tx_controller #(
    parameter int         C_S00_AXI_DATA_WIDTH = 32,
    parameter int         C_S00_AXI_ADDR_WIDTH = 4,
    parameter int         FIFO_DEPTH           = 8,
    parameter logic [7:0] IDLE_BYTE            = 8'hAA
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                          s00_axi_awprot,
    input  logic                                s00_axi_awvalid,
    output logic                                s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                                s00_axi_wvalid,
    output logic                                s00_axi_wready,
    output logic [1:0]                          s00_axi_bresp,
    output logic                                s00_axi_bvalid,
    input  logic                                s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                          s00_axi_arprot,
    input  logic                                s00_axi_arvalid,
    output logic                                s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                          s00_axi_rresp,
    output logic                                s00_axi_rvalid,
    input  logic                                s00_axi_rready,
    output logic                                tx_serial,
    output logic                                tx_byte_strobe,
    output logic                                tx_busy
);
    localparam int         AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [8:0] DEPTH  = 9'(FIFO_DEPTH);
    localparam logic [1:0] A_CTRL = 2'd0;
    localparam logic [1:0] A_DATA = 2'd1;
    localparam logic [1:0] A_STAT = 2'd2;
    localparam logic [1:0] A_BCNT = 2'd3;

    logic          awready_q, awready_d, bvalid_q, bvalid_d;
    logic          arready_q, arready_d, rvalid_q, rvalid_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          enable_q, enable_d, overflow_q, overflow_d;
    logic [7:0]    last_byte_q, last_byte_d;
    logic [31:0]   byte_cnt_q, byte_cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [8:0]    level_q, level_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          strobe_q, strobe_d, busy_q, busy_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic       wr_en, rd_en, ctrl_wr, flush, push, push_ok, pop, run, slot_start;
    logic       stat_w1c, bcnt_wr, fifo_empty, fifo_full;
    logic [1:0] wsel, rsel;
    logic [7:0] head;
    logic [31:0] rd_word;
    logic       unused_ok;

    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0],
                         s00_axi_wdata[31:20], s00_axi_wdata[18:8], s00_axi_wstrb[3], s00_axi_wstrb[1]};

    assign wsel       = s00_axi_awaddr[3:2];
    assign rsel       = s00_axi_araddr[3:2];
    assign wr_en      = awready_q & s00_axi_awvalid & s00_axi_wvalid;
    assign rd_en      = arready_q & s00_axi_arvalid;
    assign ctrl_wr    = wr_en & (wsel == A_CTRL) & s00_axi_wstrb[0];
    assign flush      = ctrl_wr & s00_axi_wdata[1];
    assign push       = wr_en & (wsel == A_DATA) & s00_axi_wstrb[0];
    assign stat_w1c   = wr_en & (wsel == A_STAT) & s00_axi_wstrb[2] & s00_axi_wdata[19];
    assign bcnt_wr    = wr_en & (wsel == A_BCNT);
    assign fifo_empty = (level_q == 9'd0);
    assign fifo_full  = (level_q == DEPTH);
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        enable_d = enable_q;
        if (ctrl_wr) enable_d = s00_axi_wdata[0];
    end

    // A disable write aborts on its own edge, so the slot must not pop then.
    assign run        = enable_q & enable_d;
    assign slot_start = run & (bit_cnt_q == 3'd0);
    assign pop        = slot_start & ~fifo_empty & ~flush;
    assign push_ok    = push & (~fifo_full | pop);

    always_comb begin
        rd_word = 32'd0;
        case (rsel)
            A_CTRL:  rd_word = {31'd0, enable_q};
            A_DATA:  rd_word = {24'd0, last_byte_q};
            A_STAT:  rd_word = {12'd0, overflow_q, busy_q, fifo_full, fifo_empty, 7'd0, level_q};
            default: rd_word = byte_cnt_q;
        endcase
    end

    always_comb begin
        awready_d = s00_axi_awvalid & s00_axi_wvalid & ~bvalid_q & ~awready_q;
        bvalid_d  = bvalid_q;
        if (bvalid_q && s00_axi_bready) bvalid_d = 1'b0;
        if (wr_en) bvalid_d = 1'b1;

        arready_d = s00_axi_arvalid & ~rvalid_q & ~arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        if (rd_en) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word;
        end else if (rvalid_q && s00_axi_rready) begin
            rvalid_d = 1'b0;
        end

        last_byte_d = push ? s00_axi_wdata[7:0] : last_byte_q;
        overflow_d  = overflow_q;
        if (push && fifo_full && !pop) overflow_d = 1'b1;
        else if (stat_w1c)             overflow_d = 1'b0;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
            level_d = level_q + {8'd0, push_ok} - {8'd0, pop};
        end

        if (!run) begin
            bit_cnt_d = 3'd0;
            shift_d   = 8'd0;
            strobe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (bit_cnt_q == 3'd0) begin
            bit_cnt_d = 3'd1;
            shift_d   = pop ? head : IDLE_BYTE;
            strobe_d  = pop;
            busy_d    = pop;
        end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {shift_q[6:0], 1'b0};
            strobe_d  = 1'b0;
            busy_d    = busy_q;
        end

        byte_cnt_d = byte_cnt_q;
        if (bcnt_wr) byte_cnt_d = 32'd0;
        else if (run && busy_q && bit_cnt_q == 3'd7) byte_cnt_d = byte_cnt_q + 32'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            awready_q   <= 1'b0;
            bvalid_q    <= 1'b0;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            enable_q    <= 1'b0;
            overflow_q  <= 1'b0;
            last_byte_q <= '0;
            byte_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            strobe_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            awready_q   <= awready_d;
            bvalid_q    <= bvalid_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            enable_q    <= enable_d;
            overflow_q  <= overflow_d;
            last_byte_q <= last_byte_d;
            byte_cnt_q  <= byte_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            strobe_q    <= strobe_d;
            busy_q      <= busy_d;
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= s00_axi_wdata[7:0];
    end

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = awready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = 2'b00;
    assign tx_serial       = shift_q[7];
    assign tx_byte_strobe  = strobe_q;
    assign tx_busy         = busy_q;
endmodule

// File: tb/tb_tx_controller.sv
// Bench for tx_controller: register table, hand-written corner sequences and a
// randomized push/drain phase checked against a byte-queue model.
module tb_tx_controller;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        tx_serial, tx_byte_strobe, tx_busy;

    localparam logic [3:0] CTRL = 4'h0, TXD = 4'h4, STAT = 4'h8, BCNT = 4'hC;

    tx_controller dut (
        .clock(clock), .reset(reset),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
        .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
        .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready), .tx_serial(tx_serial), .tx_byte_strobe(tx_byte_strobe),
        .tx_busy(tx_busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0, passes = 0;
    int hs_cyc = 0, st_cyc = 0;

    // Reference model: bytes accepted but not yet seen on the line.
    logic [7:0] mq[$];
    bit  m_ovf = 0, mdl_on = 0, mon_en = 0;
    int  m_sent = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input bit br);
        int n = 0;
        @(negedge clock);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = br;
        while (!awready && n < 20) begin @(negedge clock); n++; end
        if (!awready) chk("awready_timeout", {31'd0, awready}, 32'd1);
        @(posedge clock);
        hs_cyc = cyc;
        if (mdl_on) begin
            case (a[3:2])
                2'd0: if (s[0] && d[1]) mq.delete();
                2'd1: if (s[0]) begin
                          if (mq.size() < 8) mq.push_back(d[7:0]);
                          else m_ovf = 1;
                      end
                2'd2: if (s[2] && d[19]) m_ovf = 0;
                default: m_sent = 0;
            endcase
        end
        @(negedge clock);
        awvalid = 0; wvalid = 0;
        chk("bvalid_bresp", {29'd0, bvalid, bresp}, 32'h4);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        axi_write(a, d, 4'hF, 1'b1);
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        int n = 0;
        @(negedge clock);
        araddr = a; arvalid = 1; rready = 0;
        while (!arready && n < 20) begin @(negedge clock); n++; end
        if (!arready) chk("arready_timeout", {31'd0, arready}, 32'd1);
        @(posedge clock);
        @(negedge clock);
        arvalid = 0;
        chk("rvalid_rresp", {29'd0, rvalid, rresp}, 32'h4);
        d = rdata;
        rready = 1;
        @(negedge clock);
        rready = 0;
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] v;
        axi_read(a, v);
        chk(name, v, exp);
    endtask

    task automatic wait_strobe(output bit ok);
        int n = 0;
        while (!tx_byte_strobe && n < 24) begin @(negedge clock); n++; end
        ok = tx_byte_strobe;
        st_cyc = cyc;
    endtask

    task automatic get_byte(output logic [7:0] b, output bit ok, output bit allbusy);
        b = 0; allbusy = 1;
        wait_strobe(ok);
        if (ok) begin
            for (int i = 0; i < 8; i++) begin
                if (i > 0) @(negedge clock);
                b = {b[6:0], tx_serial};
                allbusy &= tx_busy;
            end
        end
    endtask

    function automatic logic [31:0] model_status();
        int sz = mq.size();
        return (m_ovf ? 32'h80000 : 32'h0) | ((sz == 8) ? 32'h20000 : 32'h0) |
               ((sz == 0) ? 32'h10000 : 32'h0) | 32'(sz);
    endfunction

    // Line monitor for the randomized phase: every strobed byte must be the model's head.
    initial begin
        logic [7:0] mb;
        forever begin
            @(negedge clock);
            if (mon_en && tx_byte_strobe) begin
                mb = 0;
                for (int i = 0; i < 8; i++) begin
                    if (i > 0) @(negedge clock);
                    mb = {mb[6:0], tx_serial};
                end
                if (mq.size() == 0) begin
                    checks++;
                    $display("FAIL mon_byte: got 0x%0h, expected no byte", mb);
                end else begin
                    chk("mon_byte", {24'd0, mb}, {24'd0, mq.pop_front()});
                    m_sent++;
                end
            end
        end
    end

    typedef struct {
        bit          wr;
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [3:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[11];

    initial begin
        logic [7:0] b, b2;
        bit ok, ab, sor;
        int lat;

        vt[0]  = '{1'b1, CTRL, 32'h1,        4'hF, CTRL, 32'h1};
        vt[1]  = '{1'b1, CTRL, 32'h3,        4'hF, CTRL, 32'h1};
        vt[2]  = '{1'b1, CTRL, 32'h0,        4'hF, CTRL, 32'h0};
        vt[3]  = '{1'b1, TXD,  32'h5A,       4'hF, TXD,  32'h5A};
        vt[4]  = '{1'b0, TXD,  32'h0,        4'h0, STAT, 32'h1};
        vt[5]  = '{1'b1, TXD,  32'hABCD01C3, 4'hE, TXD,  32'h5A};
        vt[6]  = '{1'b1, STAT, 32'hFFFFFFFF, 4'hF, STAT, 32'h1};
        vt[7]  = '{1'b1, TXD,  32'h77,       4'hF, STAT, 32'h2};
        vt[8]  = '{1'b1, CTRL, 32'h2,        4'hF, STAT, 32'h10000};
        vt[9]  = '{1'b1, BCNT, 32'hDEAD,     4'hF, BCNT, 32'h0};
        vt[10] = '{1'b0, CTRL, 32'h0,        4'h0, CTRL, 32'h0};

        // reset state
        repeat (3) @(negedge clock);
        chk("reset_outputs", {21'd0, awready, wready, bvalid, arready, rvalid, tx_serial,
                              tx_byte_strobe, tx_busy, bresp, rresp}, 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        reset = 0;
        rd_chk("reset_status", STAT, 32'h10000);

        for (int i = 0; i < 11; i++) begin
            if (vt[i].wr) axi_write(vt[i].waddr, vt[i].wdata, vt[i].wstrb, 1'b1);
            rd_chk($sformatf("vec%0d", i), vt[i].raddr, vt[i].exp);
        end

        // bvalid must hold until bready
        axi_write(CTRL, 32'h1, 4'hF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bvalid_hold", {31'd0, bvalid}, 32'd1);
        end
        bready = 1;
        @(negedge clock);
        chk("bvalid_release", {31'd0, bvalid}, 32'd0);

        // single byte, latency, idle fill
        wr(TXD, 32'hA5);
        get_byte(b, ok, ab);
        lat = st_cyc - hs_cyc;
        chk("single_strobe", {31'd0, ok}, 32'd1);
        chk("single_latency_2_9", {31'd0, (lat >= 2 && lat <= 9)}, 32'd1);
        chk("single_byte", {24'd0, b}, 32'hA5);
        chk("single_busy", {31'd0, ab}, 32'd1);
        b2 = 0; sor = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            b2 = {b2[6:0], tx_serial};
            sor |= tx_byte_strobe | tx_busy;
        end
        chk("idle_byte", {24'd0, b2}, 32'hAA);
        chk("idle_no_strobe_busy", {31'd0, sor}, 32'd0);
        rd_chk("single_bcnt", BCNT, 32'd1);
        rd_chk("single_status", STAT, 32'h10000);

        // overflow
        wr(CTRL, 32'h0);
        wr(BCNT, 32'h0);
        for (int i = 1; i <= 9; i++) wr(TXD, 32'(i));
        rd_chk("ovf_status", STAT, 32'h000A0008);
        wr(CTRL, 32'h1);
        for (int i = 1; i <= 8; i++) begin
            get_byte(b, ok, ab);
            chk($sformatf("ovf_byte%0d", i), {23'd0, ok, b}, 32'h100 | 32'(i));
        end
        rd_chk("ovf_after_drain", STAT, 32'h00090000);
        rd_chk("ovf_bcnt", BCNT, 32'd8);
        wr(STAT, 32'h00080000);
        rd_chk("ovf_w1c", STAT, 32'h10000);

        // byte count of 3
        wr(BCNT, 32'h55);
        wr(TXD, 32'h31); wr(TXD, 32'h32); wr(TXD, 32'h33);
        repeat (40) @(negedge clock);
        rd_chk("bcnt3", BCNT, 32'd3);

        // flush with a byte in flight
        wr(CTRL, 32'h0);
        wr(BCNT, 32'h0);
        for (int i = 0; i < 5; i++) wr(TXD, 32'h11 + 32'(i));
        wr(CTRL, 32'h1);
        wait_strobe(ok);
        chk("flush_strobe", {31'd0, ok}, 32'd1);
        b = 0; b2 = 0; sor = 0;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    if (i > 0) @(negedge clock);
                    if (i < 8) b = {b[6:0], tx_serial};
                    else begin b2 = {b2[6:0], tx_serial}; sor |= tx_byte_strobe; end
                end
            end
            wr(CTRL, 32'h3);
        join
        chk("flush_inflight", {24'd0, b}, 32'h11);
        chk("flush_next_idle", {24'd0, b2}, 32'hAA);
        chk("flush_no_strobe", {31'd0, sor}, 32'd0);
        repeat (10) @(negedge clock);
        rd_chk("flush_bcnt", BCNT, 32'd1);
        rd_chk("flush_status", STAT, 32'h10000);

        // randomized rounds against the queue model
        wr(CTRL, 32'h0);
        mq.delete(); m_ovf = 0; m_sent = 0;
        mdl_on = 1; mon_en = 1;
        wr(BCNT, 32'h0);
        for (int r = 0; r < 6; r++) begin
            int n, k, w;
            wr(CTRL, 32'h0);
            n = $urandom_range(0, 12);
            for (int i = 0; i < n; i++) wr(TXD, $urandom);
            if ($urandom_range(0, 1) == 1) wr(STAT, 32'h00080000);
            rd_chk($sformatf("rnd%0d_status", r), STAT, model_status());
            wr(CTRL, 32'h1);
            if (mq.size() <= 4) begin
                k = $urandom_range(0, 3);
                for (int i = 0; i < k; i++) axi_write(TXD, $urandom, 4'h1, 1'b1);
            end
            w = 0;
            while (mq.size() != 0 && w < 300) begin @(negedge clock); w++; end
            chk($sformatf("rnd%0d_drain", r), 32'(mq.size()), 32'd0);
            repeat (12) @(negedge clock);
            rd_chk($sformatf("rnd%0d_bcnt", r), BCNT, 32'(m_sent));
            rd_chk($sformatf("rnd%0d_final", r), STAT, model_status());
        end
        mon_en = 0; mdl_on = 0;

        // reset in the middle of a byte
        wr(TXD, 32'hFF);
        wait_strobe(ok);
        @(negedge clock); @(negedge clock);
        chk("pre_reset_line", {30'd0, tx_serial, tx_busy}, 32'h3);
        #2 reset = 1;
        #1;
        chk("midreset_outputs", {21'd0, awready, wready, bvalid, arready, rvalid, tx_serial,
                                 tx_byte_strobe, tx_busy, bresp, rresp}, 32'h0);
        chk("midreset_rdata", rdata, 32'h0);
        @(negedge clock);
        reset = 0;
        rd_chk("midreset_status", STAT, 32'h10000);
        rd_chk("midreset_ctrl", CTRL, 32'h0);
        rd_chk("midreset_bcnt", BCNT, 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
